// File: rtl/axis_hdr_pkg.sv
// Package for the AXI-Stream header inserter.
// Provides the FSM state type and byte-mask helpers shared by the top level and
// the byte-merge datapath. The helpers work on a fixed MaxBytes-wide mask so one
// definition serves every data width; callers size-cast results to their bus.
package axis_hdr_pkg;

  // Widest bus (in bytes) the helpers support.
  localparam int unsigned MaxBytes = 64;

  typedef logic [MaxBytes-1:0] bmask_t;

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StFlush
  } state_e;

  // Number of set bits in a byte mask.
  function automatic int unsigned popcount(input bmask_t m);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < MaxBytes; i++) begin
      if (m[i]) n++;
    end
    return n;
  endfunction

  // Low n bits set.
  function automatic bmask_t lsb_mask(input int unsigned n);
    bmask_t m;
    m = '0;
    for (int unsigned i = 0; i < MaxBytes; i++) begin
      m[i] = (i < n);
    end
    return m;
  endfunction

  // Top n bits of a w-bit mask set (bits w-1 down to w-n).
  function automatic bmask_t msb_mask(input int unsigned n, input int unsigned w);
    bmask_t m;
    m = '0;
    for (int unsigned i = 0; i < MaxBytes; i++) begin
      m[i] = (i < w) && (i + n >= w);
    end
    return m;
  endfunction

  // One keep bit per byte expanded to eight data bits.
  function automatic logic [MaxBytes*8-1:0] byte_expand(input bmask_t m);
    logic [MaxBytes*8-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MaxBytes; i++) begin
      r[8*i +: 8] = {8{m[i]}};
    end
    return r;
  endfunction

endpackage

// File: rtl/axis_byte_merge.sv
// Combinational residue + payload merge for the header inserter.
// The stream seen on the wire is {residue low H bytes, payload top K bytes}; the
// first DATA_BYTE_WD bytes of that stream form the output beat and the payload's
// low H bytes become the next residue.
// Ports:
//   residue_i  carried-over bytes, valid in the low H byte lanes
//   hlen_i     H, header length in bytes (constant for a packet)
//   data_i     payload beat, MSB byte first
//   keep_i     payload keep, MSB-aligned contiguous (K = popcount)
//   data_o     merged output beat, bytes with keep_o=0 are zero
//   keep_o     all-ones when H+K exceeds a beat, else top H+K ones
//   residue_o  next residue (payload low H bytes)
//   ovf_o      H+K > DATA_BYTE_WD, i.e. a last beat needs a flush beat
//   rem_o      H+K-DATA_BYTE_WD, byte count of that flush beat
module axis_byte_merge
  import axis_hdr_pkg::*;
#(
  parameter int unsigned DATA_WD      = 32,
  parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
  parameter int unsigned CNT_WD       = $clog2(DATA_BYTE_WD + 1)
) (
  input  logic [DATA_WD-1:0]      residue_i,
  input  logic [CNT_WD-1:0]       hlen_i,
  input  logic [DATA_WD-1:0]      data_i,
  input  logic [DATA_BYTE_WD-1:0] keep_i,
  output logic [DATA_WD-1:0]      data_o,
  output logic [DATA_BYTE_WD-1:0] keep_o,
  output logic [DATA_WD-1:0]      residue_o,
  output logic                    ovf_o,
  output logic [CNT_WD-1:0]       rem_o
);

  localparam logic [CNT_WD:0] BytesW = (CNT_WD + 1)'(DATA_BYTE_WD);

  logic [CNT_WD-1:0] kcnt;
  logic [CNT_WD:0]   total;
  logic [CNT_WD+3:0] rshamt;
  logic [DATA_WD-1:0] raw;

  always_comb begin
    kcnt   = CNT_WD'(popcount(MaxBytes'(keep_i)));
    total  = {1'b0, hlen_i} + {1'b0, kcnt};
    ovf_o  = (total > BytesW);
    rem_o  = CNT_WD'(total - BytesW);
    // Dropping the H unsent payload bytes off the bottom of {residue, data}
    // leaves the output beat in the low DATA_WD bits.
    rshamt = {1'b0, hlen_i, 3'b000};
    raw    = DATA_WD'({residue_i, data_i} >> rshamt);
    keep_o = ovf_o ? '1 : DATA_BYTE_WD'(msb_mask(32'(total), DATA_BYTE_WD));
    data_o = raw & DATA_WD'(byte_expand(MaxBytes'(keep_o)));
    residue_o = data_i & DATA_WD'(byte_expand(lsb_mask(32'(hlen_i))));
  end

endmodule

// File: rtl/axis_hdr_insert_gen.sv
// AXI-Stream header inserter: prepends a 0..DATA_BYTE_WD byte header to each
// packet, registered output, 1 beat/cycle with full backpressure, and a flush
// beat when header plus last payload beat overflow one beat.
// Optional build macro HDR_INS_CHECK_EN adds a sticky keep-protocol checker on
// err_out; without it err_out is tied low. The datapath is identical either way.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   valid_in/data_in/keep_in/last_in payload input, ready_in back to source
//   valid_out/data_out/keep_out/last_out merged output, ready_out from sink
//   valid_insert/header_insert/keep_insert header input, ready_insert back
//   err_out                          sticky protocol error
module axis_hdr_insert_gen
  import axis_hdr_pkg::*;
#(
  parameter int unsigned DATA_WD      = 32,
  parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
  parameter int unsigned CNT_WD       = $clog2(DATA_BYTE_WD + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  input  logic                    valid_insert,
  input  logic [DATA_WD-1:0]      header_insert,
  input  logic [DATA_BYTE_WD-1:0] keep_insert,
  output logic                    ready_insert,
  output logic                    err_out
);

  localparam logic [CNT_WD:0] BytesW = (CNT_WD + 1)'(DATA_BYTE_WD);

  state_e                  state_q, state_d;
  logic [DATA_WD-1:0]      residue_q, residue_d;
  logic [CNT_WD-1:0]       hlen_q, hlen_d;
  logic [CNT_WD-1:0]       flush_cnt_q, flush_cnt_d;
  logic                    valid_q, valid_d;
  logic [DATA_WD-1:0]      data_q, data_d;
  logic [DATA_BYTE_WD-1:0] keep_q, keep_d;
  logic                    last_q, last_d;

  logic                    load;
  logic                    hdr_hs;
  logic                    in_hs;
  logic [CNT_WD-1:0]       hdr_cnt;
  logic [DATA_WD-1:0]      hdr_bytes;
  logic [CNT_WD+3:0]       flush_shamt;
  logic [DATA_BYTE_WD-1:0] flush_keep;
  logic [DATA_WD-1:0]      flush_data;

  logic [DATA_WD-1:0]      mrg_data;
  logic [DATA_BYTE_WD-1:0] mrg_keep;
  logic [DATA_WD-1:0]      mrg_res;
  logic                    mrg_ovf;
  logic [CNT_WD-1:0]       mrg_rem;

  assign load         = ~valid_q | ready_out;
  assign ready_insert = (state_q == StIdle);
  assign ready_in     = (state_q == StStream) & load;
  assign hdr_hs       = valid_insert & ready_insert;
  assign in_hs        = valid_in & ready_in;

  assign valid_out = valid_q;
  assign data_out  = data_q;
  assign keep_out  = keep_q;
  assign last_out  = last_q;

  axis_byte_merge #(
    .DATA_WD      (DATA_WD),
    .DATA_BYTE_WD (DATA_BYTE_WD),
    .CNT_WD       (CNT_WD)
  ) u_merge (
    .residue_i (residue_q),
    .hlen_i    (hlen_q),
    .data_i    (data_in),
    .keep_i    (keep_in),
    .data_o    (mrg_data),
    .keep_o    (mrg_keep),
    .residue_o (mrg_res),
    .ovf_o     (mrg_ovf),
    .rem_o     (mrg_rem)
  );

  always_comb begin
    hdr_cnt   = CNT_WD'(popcount(MaxBytes'(keep_insert)));
    hdr_bytes = header_insert & DATA_WD'(byte_expand(lsb_mask(32'(hdr_cnt))));
    // Flush beat: the leftover residue bytes moved up to the MSB lanes.
    flush_shamt = {(BytesW - {1'b0, hlen_q}), 3'b000};
    flush_keep  = DATA_BYTE_WD'(msb_mask(32'(flush_cnt_q), DATA_BYTE_WD));
    flush_data  = (residue_q << flush_shamt) & DATA_WD'(byte_expand(MaxBytes'(flush_keep)));
  end

  always_comb begin
    state_d     = state_q;
    residue_d   = residue_q;
    hlen_d      = hlen_q;
    flush_cnt_d = flush_cnt_q;
    valid_d     = valid_q;
    data_d      = data_q;
    keep_d      = keep_q;
    last_d      = last_q;

    // A consumed (or empty) output slot goes idle unless refilled below.
    if (load) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (hdr_hs) begin
          hlen_d    = hdr_cnt;
          residue_d = hdr_bytes;
          state_d   = StStream;
        end
      end
      StStream: begin
        if (in_hs) begin
          valid_d   = 1'b1;
          data_d    = mrg_data;
          keep_d    = mrg_keep;
          last_d    = last_in & ~mrg_ovf;
          residue_d = mrg_res;
          if (last_in) begin
            if (mrg_ovf) begin
              flush_cnt_d = mrg_rem;
              state_d     = StFlush;
            end else begin
              state_d = StIdle;
            end
          end
        end
      end
      StFlush: begin
        if (load) begin
          valid_d = 1'b1;
          data_d  = flush_data;
          keep_d  = flush_keep;
          last_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      residue_q   <= '0;
      hlen_q      <= '0;
      flush_cnt_q <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      keep_q      <= '0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      residue_q   <= residue_d;
      hlen_q      <= hlen_d;
      flush_cnt_q <= flush_cnt_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      keep_q      <= keep_d;
      last_q      <= last_d;
    end
  end

`ifdef HDR_INS_CHECK_EN
  localparam logic [DATA_BYTE_WD-1:0] OneB = DATA_BYTE_WD'(1);

  logic                    err_q, err_d;
  logic [DATA_BYTE_WD-1:0] keep_in_inv;
  logic                    hdr_bad;
  logic                    in_bad;

  always_comb begin
    // A mask is LSB-contiguous iff adding one clears every set bit.
    hdr_bad     = |(keep_insert & (keep_insert + OneB));
    keep_in_inv = ~keep_in;
    in_bad      = (|(keep_in_inv & (keep_in_inv + OneB))) | (~last_in & ~(&keep_in));
    err_d       = err_q | (hdr_hs & hdr_bad) | (in_hs & in_bad);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_out = err_q;
`else
  assign err_out = 1'b0;
`endif

endmodule

// File: tb/tb_axis_hdr_insert_gen.sv
module tb_axis_hdr_insert_gen;

  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;

  logic          clk;
  logic          rst;
  logic          valid_in;
  logic [DW-1:0] data_in;
  logic [BW-1:0] keep_in;
  logic          last_in;
  logic          ready_in;
  logic          valid_out;
  logic [DW-1:0] data_out;
  logic [BW-1:0] keep_out;
  logic          last_out;
  logic          ready_out;
  logic          valid_insert;
  logic [DW-1:0] header_insert;
  logic [BW-1:0] keep_insert;
  logic          ready_insert;
  logic          err_out;

  typedef struct {
    logic [DW-1:0] d;
    logic [BW-1:0] k;
    logic          l;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_e;
  int    checks = 0;
  int    errors = 0;
  bit    stall_mode = 1'b0;

  axis_hdr_insert_gen #(
    .DATA_WD (DW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .valid_in      (valid_in),
    .data_in       (data_in),
    .keep_in       (keep_in),
    .last_in       (last_in),
    .ready_in      (ready_in),
    .valid_out     (valid_out),
    .data_out      (data_out),
    .keep_out      (keep_out),
    .last_out      (last_out),
    .ready_out     (ready_out),
    .valid_insert  (valid_insert),
    .header_insert (header_insert),
    .keep_insert   (keep_insert),
    .ready_insert  (ready_insert),
    .err_out       (err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sink ready: always 1, or alternating 1,0,1,0 while stall_mode is set.
  initial begin
    ready_out = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ready_out = stall_mode ? ~ready_out : 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input logic [DW-1:0] d, input logic [BW-1:0] k, input logic l);
    beat_t b;
    b.d = d;
    b.k = k;
    b.l = l;
    exp_q.push_back(b);
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Entered and left at posedge+1.
  task automatic send_hdr(input logic [DW-1:0] h, input logic [BW-1:0] k);
    int n;
    valid_insert  = 1'b1;
    header_insert = h;
    keep_insert   = k;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (ready_insert) break;
    end
    chk("hdr_handshake_wait", 32'(n < 100), 32'd1);
    sync();
    valid_insert = 1'b0;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [BW-1:0] k, input logic l);
    int n;
    valid_in = 1'b1;
    data_in  = d;
    keep_in  = k;
    last_in  = l;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (ready_in) break;
    end
    chk("beat_handshake_wait", 32'(n < 100), 32'd1);
    sync();
    valid_in = 1'b0;
    last_in  = 1'b0;
  endtask

  task automatic drain();
    int n;
    for (n = 0; n < 200 && exp_q.size() != 0; n++) @(negedge clk);
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
    sync();
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    chk("rst_valid_out", 32'(valid_out), 32'd0);
    chk("rst_ready_in", 32'(ready_in), 32'd0);
    chk("rst_ready_insert", 32'(ready_insert), 32'd1);
    exp_q.delete();
    sync();
    sync();
    rst = 1'b0;
    repeat (3) sync();
  endtask

  initial begin
    rst           = 1'b1;
    valid_in      = 1'b0;
    data_in       = '0;
    keep_in       = '0;
    last_in       = 1'b0;
    valid_insert  = 1'b0;
    header_insert = '0;
    keep_insert   = '0;

    // Output monitor: head of scoreboard must match every valid cycle, which
    // also checks the beat is held unchanged while the sink stalls.
    fork
      forever begin
        @(negedge clk);
        if (!rst && valid_out) begin
          checks++;
          assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_beat: observed %0h/%0h expected none", data_out, keep_out);
          end
          if (exp_q.size() != 0) begin
            mon_e = exp_q[0];
            chk("out_data", data_out, mon_e.d);
            chk("out_keep", 32'(keep_out), 32'(mon_e.k));
            chk("out_last", 32'(last_out), 32'(mon_e.l));
            if (ready_out) void'(exp_q.pop_front());
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    chk("reset_valid_out", 32'(valid_out), 32'd0);
    chk("reset_last_out", 32'(last_out), 32'd0);
    chk("reset_ready_in", 32'(ready_in), 32'd0);
    chk("reset_ready_insert", 32'(ready_insert), 32'd1);
    chk("reset_data_out", data_out, 32'd0);
    chk("reset_keep_out", 32'(keep_out), 32'd0);
    chk("reset_err_out", 32'(err_out), 32'd0);
    sync();
    rst = 1'b0;
    sync();

    // T1: 2-byte header, 2 full beats, flush beat.
    push_exp(32'hAABB1122, 4'b1111, 1'b0);
    push_exp(32'h33445566, 4'b1111, 1'b0);
    push_exp(32'h77880000, 4'b1100, 1'b1);
    send_hdr(32'h0000AABB, 4'b0011);
    @(negedge clk);
    chk("t1_no_hdr_in_stream", 32'(ready_insert), 32'd0);
    sync();
    send_beat(32'h11223344, 4'b1111, 1'b0);
    send_beat(32'h55667788, 4'b1111, 1'b1);
    drain();

    // T2: full-width header, 1-byte payload.
    push_exp(32'hDEADBEEF, 4'b1111, 1'b0);
    push_exp(32'h01000000, 4'b1000, 1'b1);
    send_hdr(32'hDEADBEEF, 4'b1111);
    send_beat(32'h01000000, 4'b1000, 1'b1);
    drain();

    // T3: H+K exactly one beat, no flush.
    push_exp(32'hCC112233, 4'b1111, 1'b1);
    send_hdr(32'h000000CC, 4'b0001);
    send_beat(32'h11223300, 4'b1110, 1'b1);
    drain();

    // T4: T1 under alternating backpressure.
    stall_mode = 1'b1;
    push_exp(32'hAABB1122, 4'b1111, 1'b0);
    push_exp(32'h33445566, 4'b1111, 1'b0);
    push_exp(32'h77880000, 4'b1100, 1'b1);
    send_hdr(32'h0000AABB, 4'b0011);
    send_beat(32'h11223344, 4'b1111, 1'b0);
    send_beat(32'h55667788, 4'b1111, 1'b1);
    drain();
    stall_mode = 1'b0;
    repeat (2) sync();

    // T5: reset after the first output beat, then a clean T2.
    push_exp(32'hAABB1122, 4'b1111, 1'b0);
    send_hdr(32'h0000AABB, 4'b0011);
    send_beat(32'h11223344, 4'b1111, 1'b0);
    drain();
    pulse_reset();
    push_exp(32'hDEADBEEF, 4'b1111, 1'b0);
    push_exp(32'h01000000, 4'b1000, 1'b1);
    send_hdr(32'hDEADBEEF, 4'b1111);
    send_beat(32'h01000000, 4'b1000, 1'b1);
    drain();

    // T6: empty header, passthrough; unkept bytes are zero-filled.
    push_exp(32'hA1A2A3A4, 4'b1111, 1'b0);
    push_exp(32'hB1B2B3B4, 4'b1111, 1'b0);
    push_exp(32'hC1C20000, 4'b1100, 1'b1);
    send_hdr(32'h12345678, 4'b0000);
    send_beat(32'hA1A2A3A4, 4'b1111, 1'b0);
    send_beat(32'hB1B2B3B4, 4'b1111, 1'b0);
    send_beat(32'hC1C2C3C4, 4'b1100, 1'b1);
    drain();

    // Empty beat with empty header.
    push_exp(32'h00000000, 4'b0000, 1'b1);
    send_hdr(32'h0, 4'b0000);
    send_beat(32'hFFFFFFFF, 4'b0000, 1'b1);
    drain();

    // 3-byte header; last beat fills the beat exactly.
    push_exp(32'hABCDEF11, 4'b1111, 1'b0);
    push_exp(32'h22334455, 4'b1111, 1'b1);
    send_hdr(32'h00ABCDEF, 4'b0111);
    send_beat(32'h11223344, 4'b1111, 1'b0);
    send_beat(32'h55000000, 4'b1000, 1'b1);
    drain();

`ifdef HDR_INS_CHECK_EN
    send_hdr(32'h00110022, 4'b0101);
    @(negedge clk);
    chk("err_bad_keep_insert", 32'(err_out), 32'd1);
    sync();
    pulse_reset();
    chk("err_cleared_by_reset", 32'(err_out), 32'd0);
`else
    chk("err_tied_low", 32'(err_out), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
